// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU: walks each instruction through
// fetch, decode, execute and optional write-back, driving all datapath enables/selects.
module instr_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [7:0] opcode,
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       ir_en,
  output logic       addr_sel,
  output logic       mem_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       flags_en,
  output logic       instr_done,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STOR, C_JAL, C_JCOND, C_BCOND, C_HALT
  } class_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  state_t cur_state, nxt_state;
  class_t op_class;
  logic   taken;
  logic   f_c, f_l, f_f, f_z, f_n;

  assign {f_c, f_l, f_f, f_z, f_n} = flags;
  assign state = cur_state;

  // Exact encodings win over the Bcond nibble match; 8'hFF has a high nibble of F.
  always_comb begin
    op_class = C_ALU;
    if (opcode == 8'h40)           op_class = C_LOAD;
    else if (opcode == 8'h44)      op_class = C_STOR;
    else if (opcode == 8'h48)      op_class = C_JAL;
    else if (opcode == 8'h4C)      op_class = C_JCOND;
    else if (opcode == 8'hFF)      op_class = C_HALT;
    else if (opcode[7:4] == 4'hC)  op_class = C_BCOND;
  end

  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = f_z;
      4'h1: taken = !f_z;
      4'h2: taken = f_c;
      4'h3: taken = !f_c;
      4'h4: taken = f_l;
      4'h5: taken = !f_l;
      4'h6: taken = f_n;
      4'h7: taken = !f_n;
      4'h8: taken = f_f;
      4'h9: taken = !f_f;
      4'hA: taken = !f_l && !f_z;
      4'hB: taken = f_l || f_z;
      4'hC: taken = !f_n && !f_z;
      4'hD: taken = f_n || f_z;
      4'hE: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:   if (run || step) nxt_state = S_FETCH;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: nxt_state = S_EXEC;
      S_EXEC: begin
        if (op_class == C_HALT)      nxt_state = S_HALT;
        else if (op_class == C_LOAD) nxt_state = S_WB;
        else                         nxt_state = run ? S_FETCH : S_IDLE;
      end
      S_WB:     nxt_state = run ? S_FETCH : S_IDLE;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    pc_sel     = PC_INC;
    ir_en      = 1'b0;
    addr_sel   = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    flags_en   = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (cur_state)
      S_DECODE: ir_en = 1'b1;
      S_EXEC: begin
        case (op_class)
          C_ALU: begin
            rf_we = 1'b1; flags_en = 1'b1; pc_en = 1'b1; instr_done = 1'b1;
          end
          C_LOAD: addr_sel = 1'b1;
          C_STOR: begin
            addr_sel = 1'b1; mem_we = 1'b1; pc_en = 1'b1; instr_done = 1'b1;
          end
          C_BCOND: begin
            pc_en = 1'b1; pc_sel = taken ? PC_DISP : PC_INC; instr_done = 1'b1;
          end
          C_JCOND: begin
            pc_en = 1'b1; pc_sel = taken ? PC_REG : PC_INC; instr_done = 1'b1;
          end
          // Link value is PC+1 as seen before this edge's PC load.
          C_JAL: begin
            rf_we = 1'b1; wb_sel = WB_LINK; pc_en = 1'b1; pc_sel = PC_REG;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_WB: begin
        addr_sel = 1'b1; rf_we = 1'b1; wb_sel = WB_MEM; pc_en = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a per-instruction cycle-list model feeds an
// expected-word queue that is compared against the packed DUT outputs every cycle.
module tb_instr_sequencer;
  localparam int W = 15;

  logic       clk, reset, run, step;
  logic [7:0] opcode;
  logic [3:0] cond;
  logic [4:0] flags;
  logic       pc_en, ir_en, addr_sel, mem_we, rf_we, flags_en, instr_done, halted;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  int n_vec = 0;
  int n_err = 0;
  bit at_idle = 1'b1;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .opcode(opcode), .cond(cond), .flags(flags),
    .pc_en(pc_en), .pc_sel(pc_sel), .ir_en(ir_en), .addr_sel(addr_sel),
    .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel), .flags_en(flags_en),
    .instr_done(instr_done), .halted(halted), .state(state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1);
  end

  assign obs = {state, pc_en, pc_sel, ir_en, addr_sel, mem_we, rf_we, wb_sel,
                flags_en, instr_done, halted};

  function automatic logic [W-1:0] pack(input logic [2:0] st, input logic pe,
      input logic [1:0] ps, input logic ie, input logic as, input logic mw,
      input logic rw, input logic [1:0] ws, input logic fe, input logic dn,
      input logic ht);
    return {st, pe, ps, ie, as, mw, rw, ws, fe, dn, ht};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference condition table, flags ordered {C, L, F, Z, N}.
  function automatic bit cond_true(input logic [3:0] c, input logic [4:0] f);
    bit fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = f;
    case (c)
      0: return fz;        1: return !fz;
      2: return fc;        3: return !fc;
      4: return fl;        5: return !fl;
      6: return fn;        7: return !fn;
      8: return ff;        9: return !ff;
      10: return !fl && !fz;
      11: return fl || fz;
      12: return !fn && !fz;
      13: return fn || fz;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected cycle list for one instruction, starting at its FETCH cycle.
  task automatic model_instr(input logic [7:0] op, input logic [3:0] c, input logic [4:0] f);
    bit t;
    t = cond_true(c, f);
    exp_q.push_back(pack(3'd1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    exp_q.push_back(pack(3'd2, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    if (op == 8'h40) begin
      exp_q.push_back(pack(3'd3, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 0, 0));
      exp_q.push_back(pack(3'd4, 1, 2'b00, 0, 1, 0, 1, 2'b01, 0, 1, 0));
    end else if (op == 8'h44)
      exp_q.push_back(pack(3'd3, 1, 2'b00, 0, 1, 1, 0, 2'b00, 0, 1, 0));
    else if (op == 8'h48)
      exp_q.push_back(pack(3'd3, 1, 2'b10, 0, 0, 0, 1, 2'b10, 0, 1, 0));
    else if (op == 8'h4C)
      exp_q.push_back(pack(3'd3, 1, t ? 2'b10 : 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    else if (op == 8'hFF) begin
      exp_q.push_back(pack(3'd3, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
      for (int i = 0; i < 20; i++)
        exp_q.push_back(pack(3'd5, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1));
    end else if (op[7:4] == 4'hC)
      exp_q.push_back(pack(3'd3, 1, t ? 2'b01 : 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    else
      exp_q.push_back(pack(3'd3, 1, 2'b00, 0, 0, 0, 1, 2'b00, 1, 1, 0));
  endtask

  // Driver: executes one instruction from IDLE (via run or step) or from FETCH.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] c, input logic [4:0] f,
                           input bit use_step, input bit next_run);
    logic [W-1:0] e;
    opcode = op; cond = c; flags = f;
    if (at_idle) begin
      repeat ($urandom_range(0, 2)) begin
        run = 1'b0; step = 1'b0;
        check("idle_wait", obs, '0);
        tick();
      end
      run = !use_step; step = use_step;
      check("idle_launch", obs, '0);
      tick();
    end
    model_instr(op, c, f);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("op%02h_st%0d", op, e[W-1 -: 3]), obs, e);
      if (exp_q.size() == 0) begin
        run = next_run; step = $urandom_range(0, 1);
      end else begin
        run = $urandom_range(0, 1); step = $urandom_range(0, 1);
      end
      tick();
    end
    at_idle = !next_run;
  endtask

  function automatic logic [7:0] rand_op();
    logic [7:0] o;
    case ($urandom_range(0, 5))
      0: o = 8'h40;
      1: o = 8'h44;
      2: o = 8'h48;
      3: o = 8'h4C;
      4: o = {4'hC, 4'($urandom_range(0, 15))};
      default: begin
        o = 8'($urandom_range(0, 255));
        while (o == 8'h40 || o == 8'h44 || o == 8'h48 || o == 8'h4C ||
               o == 8'hFF || o[7:4] == 4'hC)
          o = 8'($urandom_range(0, 255));
      end
    endcase
    return o;
  endfunction

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0;
    opcode = 8'h05; cond = 4'h0; flags = 5'h00;
    @(negedge clk);
    check("reset_held", obs, '0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_after_reset", obs, '0);
      tick();
    end

    // Directed: ALU back-to-back, LOAD, Bcond cases, JAL, STOR, Jcond, single step.
    run_instr(8'h05, 4'h0, 5'h00, 0, 1);
    run_instr(8'h05, 4'h0, 5'h00, 0, 1);
    run_instr(8'h40, 4'h0, 5'h00, 0, 1);
    run_instr(8'hC0, 4'h0, 5'b00010, 0, 1);
    run_instr(8'hC0, 4'h0, 5'b11101, 0, 1);
    run_instr(8'hC0, 4'hF, 5'b11111, 0, 1);
    run_instr(8'hC0, 4'hE, 5'b00000, 0, 1);
    run_instr(8'h48, 4'h0, 5'h00, 0, 1);
    run_instr(8'h44, 4'h0, 5'h00, 0, 1);
    run_instr(8'h4C, 4'hA, 5'b00000, 0, 0);
    run_instr(8'h05, 4'h0, 5'h00, 1, 0);
    run_instr(8'h40, 4'h0, 5'h00, 1, 0);

    for (int i = 0; i < 60; i++)
      run_instr(rand_op(), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                bit'($urandom_range(0, 1)), (i == 59) ? 1'b0 : bit'($urandom_range(0, 1)));

    // Reset asserted during DECODE.
    opcode = 8'h05; run = 1'b1; step = 1'b0;
    check("rst_pre_idle", obs, '0);
    tick();
    check("rst_fetch", obs, pack(3'd1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    tick();
    check("rst_decode", obs, pack(3'd2, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    #2 reset = 1'b1;
    #1 check("rst_async", obs, '0);
    @(negedge clk);
    check("rst_held", obs, '0);
    reset = 1'b0; run = 1'b0;
    tick();
    check("rst_release_idle", obs, '0);
    at_idle = 1'b1;

    // HALT persists regardless of run/step; only reset exits.
    run_instr(8'hFF, 4'h0, 5'h00, bit'($urandom_range(0, 1)), 1);
    check("halt_persist", obs, pack(3'd5, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1));
    #2 reset = 1'b1;
    #1 check("halt_rst_async", obs, '0);
    @(negedge clk);
    reset = 1'b0; run = 1'b0; step = 1'b0;
    tick();
    check("halt_rst_idle", obs, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the 16-bit CPU datapath: program counter, address mux, dual-port RAM, instruction register and register file/ALU. It steps each instruction through fetch, decode, execute and optional write-back, and produces every datapath enable and select. It sits beside the instruction decoder at CPU top level. It supports free-run and single-step execution for board debug.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs low
- run  in  1  1 = free-run; 0 = wait in IDLE for step
- step  in  1  single-step request; sampled only in IDLE
- opcode  in  8  {instr[15:12], instr[7:4]} from the instruction register; stable from EXEC onward
- cond  in  4  condition field instr[11:8]
- flags  in  5  {C, L, F, Z, N} from the ALU flag register
- pc_en  out  1  PC load strobe
- pc_sel  out  2  00 = PC+1, 01 = PC+displacement, 10 = register target
- ir_en  out  1  instruction register load
- addr_sel  out  1  RAM port A address: 0 = PC, 1 = register (mux B output)
- mem_we  out  1  RAM port A write enable
- rf_we  out  1  register file write enable
- wb_sel  out  2  00 = ALU, 01 = RAM data, 10 = PC+1 (link)
- flags_en  out  1  flag register update
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- halted  out  1  high in HALT
- state  out  3  IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, WB = 4, HALT = 5

## Operation
- Instruction classes by opcode:
  - 8'h40 = LOAD
  - 8'h44 = STOR
  - 8'h48 = JAL
  - 8'h4C = Jcond
  - opcode[7:4] = 4'hC = Bcond
  - 8'hFF = HALT
  - everything else = ALU (register or immediate)
- Condition truth, cond code → condition:
  - 0 → Z
  - 1 → !Z
  - 2 → C
  - 3 → !C
  - 4 → L
  - 5 → !L
  - 6 → N
  - 7 → !N
  - 8 → F
  - 9 → !F
  - A → !L&!Z
  - B → L|Z
  - C → !N&!Z
  - D → N|Z
  - E → 1
  - F → 0
- IDLE:
  - all strobes low
  - → FETCH if run | step
- FETCH:
  - addr_sel = 0, RAM reads at PC
  - → DECODE
- DECODE:
  - ir_en = 1 (RAM read data valid this cycle)
  - → EXEC
- EXEC, by class:
  - ALU: rf_we = 1, wb_sel = 00, flags_en = 1, pc_en = 1, pc_sel = 00; completes
  - LOAD: addr_sel = 1 (read issued); → WB
  - STOR: addr_sel = 1, mem_we = 1, pc_en = 1, pc_sel = 00; completes
  - Bcond: pc_en = 1, pc_sel = 01 if taken, else 00; completes
  - Jcond: pc_en = 1, pc_sel = 10 if taken, else 00; completes
  - JAL: rf_we = 1, wb_sel = 10, pc_en = 1, pc_sel = 10, all in one cycle; the link value is PC+1 taken before the PC edge. Completes.
  - HALT: → HALT with no strobes
- WB (LOAD only):
  - addr_sel held at 1, rf_we = 1, wb_sel = 01, pc_en = 1, pc_sel = 00; completes
- Completion cycle:
  - instr_done = 1
  - next state is FETCH if run = 1, else IDLE
- HALT:
  - halted = 1, all strobes 0
  - exits only on reset
- Strobe outputs are combinational from state, opcode class, cond and flags.
- At most one of mem_we and rf_we is high in any cycle.

## Timing
- Reset is asynchronous: state = IDLE, and every output is 0 (state = 0) immediately, independent of clk.
- Reset mid-instruction aborts with no write, PC update or flag update on the following edge.
- Instruction latency from FETCH entry:
  - ALU, STOR, Bcond, Jcond, JAL: 3 cycles
  - LOAD: 4 cycles
- Free-run throughput: ALU back-to-back every 3 cycles, with no IDLE between instructions.
- Single step: step high in IDLE with run = 0 executes exactly one instruction, then returns to IDLE.
  - step held high re-triggers after each return to IDLE.
  - step outside IDLE is ignored.
- run is sampled only in IDLE and on the completion cycle. Dropping run mid-instruction finishes the current instruction.
- flags are sampled in EXEC, i.e. the flags produced by the previous instruction.

## Test plan
- Reset held, then released with run = 0: state = 0 and all outputs 0; stays in IDLE for 10 cycles.
- run = 1, opcode 8'h05 (ALU): state sequence 1, 2, 3, 1. In EXEC: rf_we = flags_en = pc_en = 1 and pc_sel = 00. instr_done pulses every 3rd cycle.
- LOAD 8'h40: EXEC addr_sel = 1 with no rf_we. Then WB: rf_we = 1, wb_sel = 01, pc_en = 1. 4-cycle period.
- Bcond opcode 8'hC0, cond 0:
  - flags Z = 1: pc_sel = 01
  - flags Z = 0: pc_sel = 00
  - cond F: never taken
  - cond E: always taken
- JAL 8'h48: in EXEC, rf_we = 1, wb_sel = 10, pc_sel = 10 in the same cycle. STOR 8'h44: mem_we = 1 with rf_we = 0.
- run = 0 with a one-cycle step pulse executes exactly one instruction.
- 8'hFF: state = 5 and halted = 1 persist for 20 cycles regardless of run and step.
- Reset asserted in DECODE: outputs 0 asynchronously; IDLE after release.
